csr_access_ctrl: RTL and testbench
==================================

Name: csr_access_ctrl

Overview:
- Sequences CSR instructions (CSRRW/CSRRS/CSRRC) onto the shared CSR field bus (en/addr/set/clear, plus ack and value return) that every CSR register module in the CSR file decodes.
- Arbitrates that bus between two requesters: the core pipeline and the debug module.
- Performs each access as a read-then-modify sequence and converts the operation into set/clear masks.
- Flags illegal accesses: unacknowledged address, write to a read-only address, or reserved op.

Parameters:
- ADDR_W, 12, CSR address width
- DATA_W, 32, CSR data width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, reset asynchronous and active-low
- core_req_i  in  1  core request
- core_op_i  in  2  01=RW, 10=RS, 11=RC, 00=reserved
- core_addr_i  in  ADDR_W  target CSR address
- core_wdata_i  in  DATA_W  operand (rs1 or imm)
- core_wr_i  in  1  0 = read-only access (RS/RC with rs1=x0)
- core_gnt_o  out  1  request accepted this cycle
- core_rsp_valid_o  out  1  one-cycle response strobe
- core_rdata_o  out  DATA_W  old CSR value
- core_err_o  out  1  illegal access, valid with rsp_valid
- dbg_req_i, dbg_op_i, dbg_addr_i, dbg_wdata_i, dbg_wr_i  in  same as core_*  debug requester inputs
- dbg_gnt_o, dbg_rsp_valid_o, dbg_rdata_o, dbg_err_o  out  same as core_*  debug requester outputs
- csr_en_o  out  1  CSR bus enable
- csr_addr_o  out  ADDR_W  CSR bus address
- csr_set_o  out  DATA_W  bits to set
- csr_clear_o  out  DATA_W  bits to clear
- csr_ack_i  in  1  OR of all CSR module acks
- csr_value_i  in  DATA_W  value of the addressed CSR, muxed by the CSR file

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer points to core.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - If any req is present, assert gnt (combinational) to the winner.
  - Latch op/addr/wdata/wr/requester id; go to READ.
  - Requesters hold req and payload stable until gnt.
- READ (cycle N+1):
  - Drive csr_en_o=1, csr_addr_o=addr, set=clear=0.
  - Capture csr_value_i into rdata and csr_ack_i into ack_q.
- READ exits:
  - No ack, or op=00: err=1 → RESP.
  - wr=1 and addr[11:10]==2'b11 (read-only space): err=1 → RESP, no write.
  - wr=0: → RESP, no write.
  - Otherwise → WRITE.
- WRITE (cycle N+2):
  - csr_en_o=1.
  - RW: set=wdata, clear=~wdata.
  - RS: set=wdata, clear=0.
  - RC: set=0, clear=wdata.
  - csr_ack_i is ignored; it was already checked in READ.
- RESP:
  - Pulse rsp_valid for one cycle to the latched requester only, with rdata (old value) and err; go to IDLE.
  - On error, rdata=0.
- Latency from gnt cycle N: write access responds at N+3; read-only or error responds at N+2.
- No new gnt until the FSM is back in IDLE; only one transaction is in flight.
- csr_en_o is never asserted in IDLE or RESP; set and clear are never both 1 on the same bit.
- Simultaneous requests: the arbiter decides (see Optional Feature); the loser sees no gnt and keeps req high.
- Reset mid-transaction: returns to IDLE immediately, no response issued, and no partial write occurs after reset deassertion.

Optional Feature:
- Macro: CSR_ACCESS_RR_EN.
- Defined: round-robin arbitration. The pointer toggles to the other requester after each grant, so under continuous contention grants alternate dbg/core.
- Undefined: fixed priority, dbg over core. The pointer register is not instantiated.

Decomposition:
- Shared package csr_pkg:
  - op encodings (CSR_OP_RW/RS/RC/RSVD)
  - FSM state enum
  - read-only range constant CSR_RO_PREFIX=2'b11
  - requester id constants
- Sub-module csr_arb2: two-requester arbiter, fixed or round-robin per the macro, emitting gnt vector and winner id.

Test Plan:
- Core RW addr 0x301 wdata 0x0000_1000, CSR value 0x4000_1023 with ack → gnt N; READ N+1; WRITE N+2 with set=0x1000, clear=0xFFFF_EFFF; rsp N+3 rdata=0x4000_1023, err=0.
- Core RC wdata 0x1, then RS wdata 0x20 → set/clear = 0/0x1, then 0x20/0; the two responses return the pre-modify values.
- Core RS wr=0 addr 0x301 → no WRITE cycle; rsp at N+2 with rdata=value, err=0.
- Write to 0xC00, or any address with no ack → err=1 at N+2, rdata=0, csr_en_o high only in READ.
- core_req and dbg_req held together for 4 transactions → fixed priority: all dbg; with CSR_ACCESS_RR_EN: dbg, core, dbg, core.
- Assert rst_ni low during WRITE → all outputs 0 asynchronously; no rsp_valid; the next request is served normally.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants and types for the CSR access controller and its arbiter.
package csr_pkg;

  localparam logic [1:0] CSR_OP_RSVD = 2'b00;
  localparam logic [1:0] CSR_OP_RW   = 2'b01;
  localparam logic [1:0] CSR_OP_RS   = 2'b10;
  localparam logic [1:0] CSR_OP_RC   = 2'b11;

  // Top two address bits equal to this mark a read-only CSR.
  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } csr_state_e;

endpackage

// File: rtl/csr_arb2.sv
// Two-requester arbiter (core / debug). Round-robin when CSR_ACCESS_RR_EN is
// defined, otherwise fixed priority with debug over core.
module csr_arb2
  import csr_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       id_o
);

`ifdef CSR_ACCESS_RR_EN
  // Pointer holds the last winner; the other requester has priority next.
  logic r_ptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= REQ_CORE;
    end else if (|gnt_o) begin
      r_ptr <= id_o;
    end
  end

  always_comb begin
    id_o = REQ_CORE;
    if (&req_i) begin
      id_o = ~r_ptr;
    end else if (req_i[REQ_DBG]) begin
      id_o = REQ_DBG;
    end
  end
`else
  logic w_unused_clk;
  assign w_unused_clk = clk_i ^ rst_ni;

  always_comb begin
    id_o = REQ_CORE;
    if (req_i[REQ_DBG]) begin
      id_o = REQ_DBG;
    end
  end
`endif

  always_comb begin
    gnt_o = 2'b00;
    if (en_i && (|req_i)) begin
      gnt_o[id_o] = 1'b1;
    end
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequences CSRRW/CSRRS/CSRRC accesses from core or debug onto the CSR field
// bus as read-then-modify. Arbitration mode selected by CSR_ACCESS_RR_EN.
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_req_i,
  input  logic [1:0]        core_op_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  input  logic              core_wr_i,
  output logic              core_gnt_o,
  output logic              core_rsp_valid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_err_o,
  input  logic              dbg_req_i,
  input  logic [1:0]        dbg_op_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic              dbg_wr_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rsp_valid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_err_o,
  output logic              csr_en_o,
  output logic [ADDR_W-1:0] csr_addr_o,
  output logic [DATA_W-1:0] csr_set_o,
  output logic [DATA_W-1:0] csr_clear_o,
  input  logic              csr_ack_i,
  input  logic [DATA_W-1:0] csr_value_i
);

  csr_state_e        r_state, w_state_nxt;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_wr;
  logic              r_id;
  logic              r_err;

  logic [1:0]        w_gnt;
  logic              w_win_id;
  logic              w_idle;
  logic              w_rd_err;

  assign w_idle = (r_state == StIdle);

  csr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (w_idle),
    .req_i  ({dbg_req_i, core_req_i}),
    .gnt_o  (w_gnt),
    .id_o   (w_win_id)
  );

  assign core_gnt_o = w_gnt[REQ_CORE];
  assign dbg_gnt_o  = w_gnt[REQ_DBG];

  assign w_rd_err = !csr_ack_i || (r_op == CSR_OP_RSVD) ||
                    (r_wr && (r_addr[ADDR_W-1 -: 2] == CSR_RO_PREFIX));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (|w_gnt) w_state_nxt = StRead;
      StRead:  w_state_nxt = (w_rd_err || !r_wr) ? StResp : StWrite;
      StWrite: w_state_nxt = StResp;
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_op    <= CSR_OP_RSVD;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_wr    <= 1'b0;
      r_id    <= REQ_CORE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_idle && (|w_gnt)) begin
        r_id    <= w_win_id;
        r_op    <= (w_win_id == REQ_DBG) ? dbg_op_i    : core_op_i;
        r_addr  <= (w_win_id == REQ_DBG) ? dbg_addr_i  : core_addr_i;
        r_wdata <= (w_win_id == REQ_DBG) ? dbg_wdata_i : core_wdata_i;
        r_wr    <= (w_win_id == REQ_DBG) ? dbg_wr_i    : core_wr_i;
      end
      if (r_state == StRead) begin
        r_rdata <= w_rd_err ? '0 : csr_value_i;
        r_err   <= w_rd_err;
      end
    end
  end

  always_comb begin
    csr_en_o         = 1'b0;
    csr_addr_o       = '0;
    csr_set_o        = '0;
    csr_clear_o      = '0;
    core_rsp_valid_o = 1'b0;
    core_rdata_o     = '0;
    core_err_o       = 1'b0;
    dbg_rsp_valid_o  = 1'b0;
    dbg_rdata_o      = '0;
    dbg_err_o        = 1'b0;
    unique case (r_state)
      StRead: begin
        csr_en_o   = 1'b1;
        csr_addr_o = r_addr;
      end
      StWrite: begin
        csr_en_o   = 1'b1;
        csr_addr_o = r_addr;
        unique case (r_op)
          CSR_OP_RW: begin
            csr_set_o   = r_wdata;
            csr_clear_o = ~r_wdata;
          end
          CSR_OP_RS: csr_set_o   = r_wdata;
          CSR_OP_RC: csr_clear_o = r_wdata;
          default: ;
        endcase
      end
      StResp: begin
        if (r_id == REQ_DBG) begin
          dbg_rsp_valid_o = 1'b1;
          dbg_rdata_o     = r_rdata;
          dbg_err_o       = r_err;
        end else begin
          core_rsp_valid_o = 1'b1;
          core_rdata_o     = r_rdata;
          core_err_o       = r_err;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: emulates a sparse CSR file on the
// field bus and checks against an arithmetic model of CSR read-modify-write.
module tb_csr_access_ctrl;
  import csr_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_req = 1'b0, dbg_req = 1'b0;
  logic [1:0]    core_op = '0, dbg_op = '0;
  logic [AW-1:0] core_addr = '0, dbg_addr = '0;
  logic [DW-1:0] core_wdata = '0, dbg_wdata = '0;
  logic          core_wr = 1'b0, dbg_wr = 1'b0;
  logic          core_gnt, core_rsp, core_err, dbg_gnt, dbg_rsp, dbg_err;
  logic [DW-1:0] core_rdata, dbg_rdata;
  logic          csr_en, csr_ack;
  logic [AW-1:0] csr_addr;
  logic [DW-1:0] csr_set, csr_clear, csr_value;

  always #5 clk = ~clk;

  csr_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_op_i(core_op), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_wr_i(core_wr), .core_gnt_o(core_gnt),
    .core_rsp_valid_o(core_rsp), .core_rdata_o(core_rdata), .core_err_o(core_err),
    .dbg_req_i(dbg_req), .dbg_op_i(dbg_op), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_wr_i(dbg_wr), .dbg_gnt_o(dbg_gnt),
    .dbg_rsp_valid_o(dbg_rsp), .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
    .csr_en_o(csr_en), .csr_addr_o(csr_addr), .csr_set_o(csr_set),
    .csr_clear_o(csr_clear), .csr_ack_i(csr_ack), .csr_value_i(csr_value)
  );

  // Emulated CSR file: sparse registers that apply set/clear on the bus.
  logic [DW-1:0] mem [4096];
  bit            present [4096];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_val = '0;

  assign csr_ack   = csr_en && present[csr_addr];
  assign csr_value = present[csr_addr] ? mem[csr_addr] : '0;

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr]     <= ld_val;
      present[ld_addr] <= 1'b1;
    end else if (csr_en && present[csr_addr]) begin
      mem[csr_addr] <= (mem[csr_addr] & ~csr_clear) | csr_set;
    end
  end

  // Reference model
  logic [DW-1:0] exp_mem [4096];
  bit            exp_present [4096];
  bit            last_dbg = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_val = v;
    @(negedge clk);
    ld_en = 1'b0;
    exp_mem[a] = v;
    exp_present[a] = 1'b1;
  endtask

  task automatic drive(input bit is_dbg, input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input bit wr);
    if (is_dbg) begin
      dbg_req = 1'b1; dbg_op = op; dbg_addr = a; dbg_wdata = wd; dbg_wr = wr;
    end else begin
      core_req = 1'b1; core_op = op; core_addr = a; core_wdata = wd; core_wr = wr;
    end
  endtask

  task automatic run_txn(input bit is_dbg, input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input bit wr);
    bit            err, wrt, got_gnt, rsp;
    logic [DW-1:0] old, nxt, eset, eclr, rdata;
    int            lat;
    err = !exp_present[a] || (op == CSR_OP_RSVD) || (wr && (a[11:10] == 2'b11));
    wrt = !err && wr;
    old = err ? '0 : exp_mem[a];
    case (op)
      CSR_OP_RW: begin eset = wd; eclr = ~wd; nxt = wd; end
      CSR_OP_RS: begin eset = wd; eclr = '0;  nxt = old | wd; end
      default:   begin eset = '0; eclr = wd;  nxt = old & ~wd; end
    endcase
    @(negedge clk);
    check_eq("idle_en", csr_en, 1'b0);
    drive(is_dbg, op, a, wd, wr);
    got_gnt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (is_dbg ? dbg_gnt : core_gnt) begin got_gnt = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("gnt", got_gnt, 1'b1);
    check_eq("gnt_other", is_dbg ? core_gnt : dbg_gnt, 1'b0);
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      core_req = 1'b0; dbg_req = 1'b0;
      check_eq("set_clr_overlap", csr_set & csr_clear, '0);
      if (k == 1) begin
        check_eq("read_en", csr_en, 1'b1);
        check_eq("read_addr", csr_addr, a);
        check_eq("read_setclr", csr_set | csr_clear, '0);
      end
      if (k == 2 && wrt) begin
        check_eq("write_en", csr_en, 1'b1);
        check_eq("write_set", csr_set, eset);
        check_eq("write_clr", csr_clear, eclr);
      end
      rsp   = is_dbg ? dbg_rsp : core_rsp;
      rdata = is_dbg ? dbg_rdata : core_rdata;
      check_eq("rsp_other", is_dbg ? core_rsp : dbg_rsp, 1'b0);
      if (rsp) begin
        lat = k;
        check_eq("rsp_rdata", rdata, old);
        check_eq("rsp_err", is_dbg ? dbg_err : core_err, err);
        check_eq("resp_en", csr_en, 1'b0);
        break;
      end
    end
    check_eq("latency", lat, wrt ? 3 : 2);
    if (wrt) exp_mem[a] = nxt;
    if (exp_present[a]) check_eq("csr_content", mem[a], exp_mem[a]);
    last_dbg = is_dbg;
  endtask

  task automatic run_contention();
    bit seen, w, exp_dbg;
    @(negedge clk);
    drive(1'b0, CSR_OP_RS, 12'h300, 32'h0, 1'b0);
    drive(1'b1, CSR_OP_RS, 12'h300, 32'h0, 1'b0);
    for (int g = 0; g < 4; g++) begin
`ifdef CSR_ACCESS_RR_EN
      exp_dbg = !last_dbg;
`else
      exp_dbg = 1'b1;
`endif
      seen = 1'b0; w = 1'b0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (core_gnt || dbg_gnt) begin seen = 1'b1; w = dbg_gnt; break; end
        @(negedge clk);
      end
      check_eq("arb_gnt_seen", seen, 1'b1);
      check_eq("arb_gnt_onehot", core_gnt & dbg_gnt, 1'b0);
      check_eq("arb_winner", w, exp_dbg);
      last_dbg = w;
      seen = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (w ? dbg_rsp : core_rsp) begin
          seen = 1'b1;
          check_eq("arb_rdata", w ? dbg_rdata : core_rdata, exp_mem[12'h300]);
          break;
        end
      end
      check_eq("arb_rsp_seen", seen, 1'b1);
    end
    core_req = 1'b0; dbg_req = 1'b0;
  endtask

  logic [AW-1:0] pool [8];

  initial begin
    pool[0] = 12'h301; pool[1] = 12'h300; pool[2] = 12'h340; pool[3] = 12'hC00;
    pool[4] = 12'hF14; pool[5] = 12'h7C0; pool[6] = 12'h123; pool[7] = 12'h5A5;

    #2;
    check_eq("rst_en", csr_en, 1'b0);
    check_eq("rst_bus", csr_addr | csr_set | csr_clear, '0);
    check_eq("rst_rsp", {core_gnt, dbg_gnt, core_rsp, dbg_rsp, core_err, dbg_err}, '0);
    check_eq("rst_rdata", core_rdata | dbg_rdata, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    load(12'h301, 32'h4000_1023);
    load(12'h300, 32'h0000_1800);
    load(12'h340, 32'hDEAD_BEEF);
    load(12'hC00, 32'h0000_C0DE);
    load(12'hF14, 32'h0000_0000);
    load(12'h7C0, 32'h1234_5678);

    // Directed cases
    run_txn(1'b0, CSR_OP_RW, 12'h301, 32'h0000_1000, 1'b1);
    run_txn(1'b0, CSR_OP_RC, 12'h301, 32'h0000_0001, 1'b1);
    run_txn(1'b0, CSR_OP_RS, 12'h301, 32'h0000_0020, 1'b1);
    run_txn(1'b0, CSR_OP_RS, 12'h301, 32'h0000_0000, 1'b0);
    run_txn(1'b0, CSR_OP_RW, 12'hC00, 32'hFFFF_FFFF, 1'b1);
    run_txn(1'b0, CSR_OP_RW, 12'h123, 32'h0000_0055, 1'b1);
    run_txn(1'b1, CSR_OP_RSVD, 12'h340, 32'h0000_0001, 1'b1);
    run_txn(1'b1, CSR_OP_RS, 12'hC00, 32'h0000_0000, 1'b0);

    run_contention();

    // Reset during WRITE: no response, no write afterwards
    @(negedge clk);
    drive(1'b0, CSR_OP_RW, 12'h301, 32'hA5A5_A5A5, 1'b1);
    #1;
    check_eq("rstw_gnt", core_gnt, 1'b1);
    @(negedge clk);
    core_req = 1'b0;
    @(negedge clk);
    check_eq("rstw_write_en", csr_en, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rstw_en", csr_en, 1'b0);
    check_eq("rstw_bus", csr_addr | csr_set | csr_clear, '0);
    check_eq("rstw_rsp", {core_gnt, dbg_gnt, core_rsp, dbg_rsp, core_err, dbg_err}, '0);
    repeat (2) begin
      @(negedge clk);
      check_eq("rstw_no_rsp", core_rsp | dbg_rsp, 1'b0);
    end
    rst_n = 1'b1;
    last_dbg = 1'b0;
    @(negedge clk);
    check_eq("rstw_no_write", mem[12'h301], exp_mem[12'h301]);
    run_txn(1'b0, CSR_OP_RS, 12'h301, 32'h0100_0000, 1'b1);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              pool[$urandom_range(0, 7)], $urandom, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
